ifu_mem_bridge: RTL and testbench
=================================

// Module: ifu_mem_bridge
// PURPOSE
//  Instruction-fetch front end placed between the instruction memory bus and the core's instruction input.
//  Generates sequential fetch PCs and issues them on a valid/ready request channel.
//  Buffers returned instructions with their PCs in a small FIFO and delivers them to the core with valid/ready.
//  A redirect (jump/branch) flushes queued instructions and discards any in-flight response.
// PARAMETERS
//  ADDR_W      64             address/PC width
//  INST_W      32             instruction width
//  FIFO_DEPTH  2              instruction buffer entries; power of 2, >= 2
//  RESET_PC    64'h8000_0000  first fetch address after reset
// PORTS
//  clk               in   1       clock; all state updates on rising edge
//  rst               in   1       synchronous reset, active-low
//  redirect_valid_i  in   1       1 = restart fetch at redirect_pc_i
//  redirect_pc_i     in   ADDR_W  redirect target
//  inst_valid_o      out  1       FIFO head valid
//  inst_ready_i      in   1       core accepts head
//  inst_o            out  INST_W  head instruction
//  pc_o              out  ADDR_W  head PC
//  mem_req_valid_o   out  1       fetch request valid
//  mem_req_ready_i   in   1       memory accepts request
//  mem_req_addr_o    out  ADDR_W  fetch address; stable while valid && !ready
//  mem_rsp_valid_i   in   1       response valid; one per accepted request, earliest 1 cycle after accept
//  mem_rsp_data_i    in   INST_W  response instruction
//  fetch_err_o       out  1       misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst==0 at edge):
//   - state=IDLE, fetch_pc=RESET_PC, FIFO empty, drop flag=0, err flag=0.
//   - All outputs 0; rsp inputs ignored.
//  FSM, at most 1 outstanding request:
//   - IDLE: ->REQ when FIFO count<FIFO_DEPTH, no redirect this cycle, err flag=0.
//     On entry, req_addr_q<=fetch_pc.
//   - REQ: mem_req_valid_o=1, mem_req_addr_o=req_addr_q.
//     On mem_req_ready_i: ->WAIT, fetch_pc<=fetch_pc+4.
//   - WAIT: on mem_rsp_valid_i: ->IDLE.
//     Push {req_addr_q, mem_rsp_data_i} unless drop flag=1 or redirect this cycle; else discard.
//   - First mem_req_valid_o high = 2nd cycle after rst goes 1.
//   - Accept->next request is >=3 cycles (accept, rsp, IDLE); no pipelining.
//  Redirect (any state):
//   - FIFO cleared; inst_valid_o=0 from next cycle.
//   - fetch_pc<=redirect_pc_i; overrides the +4 if accept is in the same cycle.
//   - In REQ: valid stays high with the old address until accepted (no retraction). Drop flag set.
//   - In WAIT (rsp not this cycle): drop flag set.
//   - In IDLE: no request issued this cycle.
//   - Drop flag clears when the dropped response arrives.
//  FIFO:
//   - Registered; pushed entry visible on inst_valid_o next cycle.
//   - Pop on inst_valid_o && inst_ready_i.
//   - Simultaneous push+pop: count unchanged.
//   - Pop in a redirect cycle counts as consumed; FIFO is cleared regardless.
//   - Overflow impossible: a request is issued only with a free slot reserved.
//   - Head outputs hold while !inst_ready_i.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Arithmetic: fetch_pc+4 wraps modulo 2^ADDR_W; no overflow flag.
//  Reset mid-operation: all state cleared; a late response from the pre-reset request is ignored (state=IDLE).
// CONFIGURATION
//  IFU_BRIDGE_MISALIGN_CHK_EN defined:
//   - Redirect with redirect_pc_i[1:0]!=0 sets err flag; fetch_err_o=err from next cycle.
//   - No requests issued while err=1; FIFO flushed as for any redirect.
//   - A later aligned redirect clears err and resumes fetch.
//  IFU_BRIDGE_MISALIGN_CHK_EN undefined:
//   - redirect_pc_i[1:0] forced to 0; fetch_err_o tied 0.
// TESTING
//  1. Reset release; mem ready=1, rsp 1 cycle after accept; inst_ready_i=1
//     -> pc_o sequence 0x80000000, 0x80000004, 0x80000008, in order, no gaps/dups.
//  2. inst_ready_i=0 -> after 2 entries: mem_req_valid_o stays 0; head pc_o=0x80000000 held.
//     Raise ready -> next request addr 0x80000008.
//  3. Redirect to 0x80001000 during WAIT -> late rsp discarded; inst_valid_o=0 next cycle;
//     next delivered pc_o=0x80001000.
//  4. Redirect to 0x80001000 in REQ with ready=0 for 3 cycles -> mem_req_addr_o stays old address;
//     its rsp dropped; next request addr 0x80001000.
//  5. Redirect coinciding with mem_rsp_valid_i and a pop -> no entry pushed; FIFO empty next cycle.
//  6. Macro on: redirect 0x80000002 -> fetch_err_o=1, no requests; redirect 0x80000010 -> err=0, fetch resumes at 0x80000010.
//     Macro off: redirect 0x80000002 -> fetch at 0x80000000.

Source files
------------

// File: rtl/ifu_mem_bridge.sv
// Instruction-fetch bridge: issues sequential fetch requests and buffers {pc, inst} for the core.
// Optional misaligned-redirect checking is enabled with IFU_BRIDGE_MISALIGN_CHK_EN.
module ifu_mem_bridge #(
   parameter int unsigned       ADDR_W     = 64,
   parameter int unsigned       INST_W     = 32,
   parameter int unsigned       FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(64'h8000_0000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   input  logic              mem_rsp_valid_i,
   input  logic [INST_W-1:0] mem_rsp_data_i,
   output logic              fetch_err_o
);

   localparam int unsigned       PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned       CntW      = PtrW + 1;
   localparam logic [CntW-1:0]   DepthCnt  = CntW'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] PcStep    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic                drop_q, drop_d;
   logic                err_q, err_d;
   logic [PtrW-1:0]     wptr_q, wptr_d;
   logic [PtrW-1:0]     rptr_q, rptr_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [INST_W-1:0]   fifo_inst_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]   fifo_pc_q   [FIFO_DEPTH];

   logic [ADDR_W-1:0]   redir_pc;
   logic                redir_misalign;
   logic                push;
   logic                pop;
   logic                fifo_full;

`ifdef IFU_BRIDGE_MISALIGN_CHK_EN
   assign redir_pc       = redirect_pc_i;
   assign redir_misalign = |redirect_pc_i[1:0];
`else
   assign redir_pc       = redirect_pc_i & AlignMask;
   assign redir_misalign = 1'b0;
`endif

   assign fifo_full = (cnt_q >= DepthCnt);
   assign pop       = inst_valid_o && inst_ready_i;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      drop_d     = drop_q;
      err_d      = err_q;
      push       = 1'b0;

      case (state_q)
         StIdle: begin
            if (!fifo_full && !redirect_valid_i && !err_q) begin
               state_d    = StReq;
               req_addr_d = fetch_pc_q;
            end
         end
         StReq: begin
            if (mem_req_ready_i) begin
               state_d = StWait;
               // A pending drop means fetch_pc already holds the redirect target.
               if (!drop_q) fetch_pc_d = fetch_pc_q + PcStep;
            end
            if (redirect_valid_i) drop_d = 1'b1;
         end
         StWait: begin
            if (mem_rsp_valid_i) begin
               state_d = StIdle;
               drop_d  = 1'b0;
               push    = !drop_q && !redirect_valid_i;
            end else if (redirect_valid_i) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (redirect_valid_i) begin
         fetch_pc_d = redir_pc;
         err_d      = redir_misalign;
      end
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (redirect_valid_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + PtrW'(1);
         if (pop)  rptr_d = rptr_q + PtrW'(1);
         cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= '0;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only observable while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst_q[wptr_q] <= mem_rsp_data_i;
         fifo_pc_q[wptr_q]   <= req_addr_q;
      end
   end

   assign inst_valid_o    = (cnt_q != '0);
   assign inst_o          = inst_valid_o ? fifo_inst_q[rptr_q] : '0;
   assign pc_o            = inst_valid_o ? fifo_pc_q[rptr_q] : '0;
   assign mem_req_valid_o = (state_q == StReq);
   assign mem_req_addr_o  = req_addr_q;
   assign fetch_err_o     = err_q;

endmodule

// File: tb/tb_ifu_mem_bridge.sv
// Directed bench for ifu_mem_bridge with a small latency-configurable memory responder.
module tb_ifu_mem_bridge;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned INST_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              redirect_valid_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              inst_valid_o;
   logic              inst_ready_i;
   logic [INST_W-1:0] inst_o;
   logic [ADDR_W-1:0] pc_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic              mem_rsp_valid_i;
   logic [INST_W-1:0] mem_rsp_data_i;
   logic              fetch_err_o;

   always #5 clk = ~clk;

   ifu_mem_bridge #(
      .ADDR_W     (ADDR_W),
      .INST_W     (INST_W),
      .FIFO_DEPTH (2),
      .RESET_PC   (64'h8000_0000)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_o           (inst_o),
      .pc_o             (pc_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_rsp_valid_i  (mem_rsp_valid_i),
      .mem_rsp_data_i   (mem_rsp_data_i),
      .fetch_err_o      (fetch_err_o)
   );

   typedef struct {
      logic        inst_ready;
      logic        mem_ready;
      logic        exp_req_valid;
      logic [63:0] exp_req_addr;
      logic        exp_inst_valid;
      logic [63:0] exp_pc;
   } vec_t;

   vec_t        tbl [9];
   int          n_checks = 0;
   int          n_errors = 0;
   int          rsp_lat  = 1;
   int          rsp_cnt  = 0;
   logic [63:0] pend_addr = '0;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   function automatic vec_t mk(input logic ir, input logic mr, input logic rv,
                               input logic [63:0] ra, input logic iv, input logic [63:0] pc);
      vec_t v;
      v.inst_ready     = ir;
      v.mem_ready      = mr;
      v.exp_req_valid  = rv;
      v.exp_req_addr   = ra;
      v.exp_inst_valid = iv;
      v.exp_pc         = pc;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock; the memory responder answers rsp_lat cycles after an accepted request.
   task automatic step();
      logic        acc;
      logic [63:0] a;
      acc = mem_req_valid_o && mem_req_ready_i;
      a   = mem_req_addr_o;
      @(posedge clk);
      #1;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
      if (acc) begin
         rsp_cnt   = rsp_lat;
         pend_addr = a;
      end
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = inst_of(pend_addr);
         end
      end
   endtask

   task automatic do_reset();
      rst              = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      inst_ready_i     = 1'b0;
      mem_req_ready_i  = 1'b0;
      mem_rsp_valid_i  = 1'b0;
      mem_rsp_data_i   = '0;
      rsp_cnt          = 0;
      rsp_lat          = 1;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic wait_req(input int max, input string name);
      int i;
      i = 0;
      while (!mem_req_valid_o && i < max) begin
         step();
         i++;
      end
      check({name, " req_valid"}, 64'(mem_req_valid_o), 64'd1);
   endtask

   task automatic wait_inst(input int max, input string name);
      int i;
      i = 0;
      while (!inst_valid_o && i < max) begin
         step();
         i++;
      end
      check({name, " inst_valid"}, 64'(inst_valid_o), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = mk(1, 1, 1, 64'h8000_0000, 0, 64'h0);
      tbl[1] = mk(1, 1, 0, 64'h0,         0, 64'h0);
      tbl[2] = mk(1, 1, 0, 64'h0,         1, 64'h8000_0000);
      tbl[3] = mk(1, 1, 1, 64'h8000_0004, 0, 64'h0);
      tbl[4] = mk(1, 1, 0, 64'h0,         0, 64'h0);
      tbl[5] = mk(1, 1, 0, 64'h0,         1, 64'h8000_0004);
      tbl[6] = mk(1, 1, 1, 64'h8000_0008, 0, 64'h0);
      tbl[7] = mk(1, 1, 0, 64'h0,         0, 64'h0);
      tbl[8] = mk(1, 1, 0, 64'h0,         1, 64'h8000_0008);

      // Reset state
      do_reset();
      check("rst inst_valid", 64'(inst_valid_o), 64'd0);
      check("rst req_valid", 64'(mem_req_valid_o), 64'd0);
      check("rst req_addr", mem_req_addr_o, 64'd0);
      check("rst pc", pc_o, 64'd0);
      check("rst inst", 64'(inst_o), 64'd0);
      check("rst err", 64'(fetch_err_o), 64'd0);

      // Sequential fetch, cycle by cycle
      for (int i = 0; i < 9; i++) begin
         inst_ready_i    = tbl[i].inst_ready;
         mem_req_ready_i = tbl[i].mem_ready;
         step();
         check($sformatf("seq[%0d] req_valid", i), 64'(mem_req_valid_o),
               64'(tbl[i].exp_req_valid));
         if (tbl[i].exp_req_valid)
            check($sformatf("seq[%0d] req_addr", i), mem_req_addr_o, tbl[i].exp_req_addr);
         check($sformatf("seq[%0d] inst_valid", i), 64'(inst_valid_o),
               64'(tbl[i].exp_inst_valid));
         if (tbl[i].exp_inst_valid) begin
            check($sformatf("seq[%0d] pc", i), pc_o, tbl[i].exp_pc);
            check($sformatf("seq[%0d] inst", i), 64'(inst_o), 64'(inst_of(tbl[i].exp_pc)));
         end
      end

      // Backpressure: FIFO fills, fetch stalls, head holds
      do_reset();
      mem_req_ready_i = 1'b1;
      repeat (6) step();
      check("bp full inst_valid", 64'(inst_valid_o), 64'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("bp stall[%0d] req_valid", i), 64'(mem_req_valid_o), 64'd0);
         check($sformatf("bp hold[%0d] pc", i), pc_o, 64'h8000_0000);
      end
      inst_ready_i = 1'b1;
      wait_req(6, "bp resume");
      check("bp resume addr", mem_req_addr_o, 64'h8000_0008);

      // Redirect during WAIT with a late response
      do_reset();
      mem_req_ready_i = 1'b1;
      repeat (3) step();
      rsp_lat = 3;
      repeat (2) step();
      check("wait pre inst_valid", 64'(inst_valid_o), 64'd1);
      check("wait pre req_valid", 64'(mem_req_valid_o), 64'd0);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 64'h8000_1000;
      step();
      redirect_valid_i = 1'b0;
      inst_ready_i     = 1'b1;
      rsp_lat          = 1;
      check("wait flush inst_valid", 64'(inst_valid_o), 64'd0);
      wait_req(8, "wait redir");
      check("wait redir addr", mem_req_addr_o, 64'h8000_1000);
      check("wait late dropped", 64'(inst_valid_o), 64'd0);
      wait_inst(6, "wait deliver");
      check("wait deliver pc", pc_o, 64'h8000_1000);
      check("wait deliver inst", 64'(inst_o), 64'(inst_of(64'h8000_1000)));

      // Redirect during REQ while memory stalls
      do_reset();
      inst_ready_i = 1'b1;
      step();
      check("req first valid", 64'(mem_req_valid_o), 64'd1);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 64'h8000_1000;
      step();
      redirect_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         check($sformatf("req hold[%0d] valid", i), 64'(mem_req_valid_o), 64'd1);
         check($sformatf("req hold[%0d] addr", i), mem_req_addr_o, 64'h8000_0000);
      end
      mem_req_ready_i = 1'b1;
      step();
      check("req accepted valid", 64'(mem_req_valid_o), 64'd0);
      step();
      check("req rsp dropped", 64'(inst_valid_o), 64'd0);
      wait_req(4, "req redir");
      check("req redir addr", mem_req_addr_o, 64'h8000_1000);

      // Redirect coinciding with a response and a pop
      do_reset();
      mem_req_ready_i = 1'b1;
      repeat (5) step();
      check("coinc pre inst_valid", 64'(inst_valid_o), 64'd1);
      check("coinc pre rsp", 64'(mem_rsp_valid_i), 64'd1);
      inst_ready_i     = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 64'h8000_2000;
      step();
      redirect_valid_i = 1'b0;
      check("coinc empty", 64'(inst_valid_o), 64'd0);
      check("coinc idle", 64'(mem_req_valid_o), 64'd0);
      step();
      check("coinc req_valid", 64'(mem_req_valid_o), 64'd1);
      check("coinc req_addr", mem_req_addr_o, 64'h8000_2000);
      wait_inst(6, "coinc deliver");
      check("coinc deliver pc", pc_o, 64'h8000_2000);

      // Reset in the middle of an outstanding request
      do_reset();
      mem_req_ready_i = 1'b1;
      rsp_lat         = 2;
      repeat (2) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("midrst req_valid", 64'(mem_req_valid_o), 64'd0);
      check("midrst inst_valid", 64'(inst_valid_o), 64'd0);
      step();
      check("midrst restart valid", 64'(mem_req_valid_o), 64'd1);
      check("midrst restart addr", mem_req_addr_o, 64'h8000_0000);
      check("midrst late ignored", 64'(inst_valid_o), 64'd0);

      // Misaligned redirect
      do_reset();
      mem_req_ready_i  = 1'b1;
      inst_ready_i     = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 64'h8000_0002;
      step();
      redirect_valid_i = 1'b0;
`ifdef IFU_BRIDGE_MISALIGN_CHK_EN
      check("mis err set", 64'(fetch_err_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("mis blocked[%0d]", i), 64'(mem_req_valid_o), 64'd0);
      end
      check("mis err held", 64'(fetch_err_o), 64'd1);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 64'h8000_0010;
      step();
      redirect_valid_i = 1'b0;
      check("mis err clear", 64'(fetch_err_o), 64'd0);
      step();
      check("mis resume valid", 64'(mem_req_valid_o), 64'd1);
      check("mis resume addr", mem_req_addr_o, 64'h8000_0010);
`else
      check("mis err tied", 64'(fetch_err_o), 64'd0);
      check("mis idle no req", 64'(mem_req_valid_o), 64'd0);
      step();
      check("mis aligned valid", 64'(mem_req_valid_o), 64'd1);
      check("mis aligned addr", mem_req_addr_o, 64'h8000_0000);
      step();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 64'h8000_0017;
      step();
      redirect_valid_i = 1'b0;
      wait_req(4, "mis second");
      check("mis second addr", mem_req_addr_o, 64'h8000_0014);
      check("mis err still 0", 64'(fetch_err_o), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
